// File: rtl/serial_packet_receiver_if.sv
// Byte-stream in / packet-out bundle for serial_packet_receiver.
//   rx_data, new_rx_data          : byte and one-cycle strobe from avr_interface
//   data, new_data                : last good payload (byte 0 in data[7:0]) and its update pulse
//   busy, error, error_code       : frame-in-progress flag, failure pulse, failure cause
//   dropped                       : saturating count of non-sync bytes discarded while idle
// master drives the byte stream; slave is the receiver.
interface serial_packet_receiver_if #(
    parameter int PACKET_BYTES = 8
);
    logic [7:0]                rx_data;
    logic                      new_rx_data;
    logic [PACKET_BYTES*8-1:0] data;
    logic                      new_data;
    logic                      busy;
    logic                      error;
    logic [1:0]                error_code;
    logic [7:0]                dropped;

    modport master (
        output rx_data, new_rx_data,
        input  data, new_data, busy, error, error_code, dropped
    );

    modport slave (
        input  rx_data, new_rx_data,
        output data, new_data, busy, error, error_code, dropped
    );
endinterface

// File: rtl/serial_packet_receiver.sv
// Frames the UART byte stream into packets of SYNC_BYTE, PACKET_BYTES payload
// bytes and an XOR checksum byte. A good packet updates data with a one-cycle
// new_data pulse; a bad checksum or an inter-byte gap of TIMEOUT_CYCLES clocks
// pulses error and records the cause in error_code (01 timeout, 10 checksum).
// Ports: clk, rst (synchronous, active high), bus (serial_packet_receiver_if.slave).
module serial_packet_receiver #(
    parameter int         PACKET_BYTES   = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 5000000
) (
    input logic                     clk,
    input logic                     rst,
    serial_packet_receiver_if.slave bus
);
    localparam int CW = $clog2(PACKET_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int DW = PACKET_BYTES * 8;
    localparam logic [CW-1:0] LAST_SLOT = CW'(PACKET_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHECK
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] byte_cnt, byte_cnt_next;
    logic [7:0]    xor_acc, xor_next;
    logic [TW-1:0] tmo_cnt, tmo_next;
    logic [DW-1:0] shadow, data_q;
    logic          shadow_we, data_load;
    logic          new_data_q, new_data_next;
    logic          error_q, error_next;
    logic [1:0]    code_q, code_next;
    logic [7:0]    dropped_q, dropped_next;
    logic          timeout_hit;

    // A strobe in the expiry cycle takes priority over the timeout.
    assign timeout_hit = !bus.new_rx_data && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_next    = state;
        byte_cnt_next = byte_cnt;
        xor_next      = xor_acc;
        tmo_next      = tmo_cnt;
        shadow_we     = 1'b0;
        data_load     = 1'b0;
        new_data_next = 1'b0;
        error_next    = 1'b0;
        code_next     = code_q;
        dropped_next  = dropped_q;

        case (state)
            IDLE: begin
                if (bus.new_rx_data) begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        state_next    = PAYLOAD;
                        byte_cnt_next = '0;
                        xor_next      = '0;
                        tmo_next      = '0;
                    end else if (dropped_q != '1) begin
                        dropped_next = dropped_q + 8'd1;
                    end
                end
            end
            PAYLOAD: begin
                if (bus.new_rx_data) begin
                    shadow_we     = 1'b1;
                    xor_next      = xor_acc ^ bus.rx_data;
                    byte_cnt_next = byte_cnt + CW'(1);
                    tmo_next      = '0;
                    if (byte_cnt == LAST_SLOT) begin
                        state_next = CHECK;
                    end
                end else if (timeout_hit) begin
                    state_next = IDLE;
                    error_next = 1'b1;
                    code_next  = 2'b01;
                end else begin
                    tmo_next = tmo_cnt + TW'(1);
                end
            end
            CHECK: begin
                if (bus.new_rx_data) begin
                    state_next = IDLE;
                    if (bus.rx_data == xor_acc) begin
                        data_load     = 1'b1;
                        new_data_next = 1'b1;
                    end else begin
                        error_next = 1'b1;
                        code_next  = 2'b10;
                    end
                end else if (timeout_hit) begin
                    state_next = IDLE;
                    error_next = 1'b1;
                    code_next  = 2'b01;
                end else begin
                    tmo_next = tmo_cnt + TW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            xor_acc    <= '0;
            tmo_cnt    <= '0;
            shadow     <= '0;
            data_q     <= '0;
            new_data_q <= 1'b0;
            error_q    <= 1'b0;
            code_q     <= '0;
            dropped_q  <= '0;
        end else begin
            state      <= state_next;
            byte_cnt   <= byte_cnt_next;
            xor_acc    <= xor_next;
            tmo_cnt    <= tmo_next;
            new_data_q <= new_data_next;
            error_q    <= error_next;
            code_q     <= code_next;
            dropped_q  <= dropped_next;
            if (data_load) begin
                data_q <= shadow;
            end
            for (int unsigned i = 0; i < PACKET_BYTES; i++) begin
                if (shadow_we && byte_cnt == CW'(i)) begin
                    shadow[i*8 +: 8] <= bus.rx_data;
                end
            end
        end
    end

    assign bus.data       = data_q;
    assign bus.new_data   = new_data_q;
    assign bus.busy       = (state != IDLE);
    assign bus.error      = error_q;
    assign bus.error_code = code_q;
    assign bus.dropped    = dropped_q;
endmodule

// File: tb/tb_serial_packet_receiver.sv
// Randomised bench for serial_packet_receiver with a packet-level reference
// model (frame queue + idle-gap counter) checked against every output each cycle.
module tb_serial_packet_receiver;
    localparam int         P    = 8;
    localparam int         TMO  = 100;
    localparam logic [7:0] SYNC = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_packet_receiver_if #(.PACKET_BYTES(P)) bus ();

    serial_packet_receiver #(
        .PACKET_BYTES(P),
        .SYNC_BYTE(SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    int nd_cnt = 0;
    int err_cnt = 0;
    int last_err_cycle = -1;

    // Reference model state
    bit          m_in_frame = 0;
    logic [7:0]  m_frame[$];
    int          m_gap = 0;
    logic [63:0] m_data = '0;
    logic        m_new_data = 0;
    logic        m_error = 0;
    logic [1:0]  m_code = '0;
    logic [7:0]  m_dropped = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic model(input logic s, input logic [7:0] b, input logic r);
        logic [7:0] x;
        m_new_data = 0;
        m_error    = 0;
        if (r) begin
            m_in_frame = 0;
            m_frame.delete();
            m_gap = 0;
            m_data = '0;
            m_code = '0;
            m_dropped = '0;
        end else if (!m_in_frame) begin
            if (s) begin
                if (b == SYNC) begin
                    m_in_frame = 1;
                    m_frame.delete();
                    m_gap = 0;
                end else if (m_dropped != 8'hFF) begin
                    m_dropped = m_dropped + 8'd1;
                end
            end
        end else if (s) begin
            m_frame.push_back(b);
            m_gap = 0;
            if (m_frame.size() == P + 1) begin
                x = '0;
                for (int k = 0; k < P; k++) x ^= m_frame[k];
                if (x == m_frame[P]) begin
                    for (int k = 0; k < P; k++) m_data[8*k +: 8] = m_frame[k];
                    m_new_data = 1;
                end else begin
                    m_error = 1;
                    m_code  = 2'b10;
                end
                m_in_frame = 0;
            end
        end else begin
            m_gap++;
            if (m_gap == TMO) begin
                m_error = 1;
                m_code = 2'b01;
                m_in_frame = 0;
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic cyc(input logic s, input logic [7:0] b, input logic r);
        bus.new_rx_data = s;
        bus.rx_data     = b;
        rst             = r;
        @(posedge clk);
        model(s, b, r);
        cycle++;
        #1;
        chk("data",       bus.data,              m_data);
        chk("new_data",   64'(bus.new_data),     64'(m_new_data));
        chk("busy",       64'(bus.busy),         64'(m_in_frame));
        chk("error",      64'(bus.error),        64'(m_error));
        chk("error_code", 64'(bus.error_code),   64'(m_code));
        chk("dropped",    64'(bus.dropped),      64'(m_dropped));
        if (bus.new_data === 1'b1) nd_cnt++;
        if (bus.error === 1'b1) begin
            err_cnt++;
            last_err_cycle = cycle;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        cyc(1'b1, b, 1'b0);
        idle(gap);
    endtask

    function automatic logic [7:0] xor64(input logic [63:0] pl);
        logic [7:0] x = '0;
        for (int k = 0; k < P; k++) x ^= pl[8*k +: 8];
        return x;
    endfunction

    // Sync + payload with gap idle cycles after each byte; checksum sent last with no trailing gap.
    task automatic send_frame(input logic [63:0] pl, input logic [7:0] ck, input int gap);
        send(SYNC, gap);
        for (int k = 0; k < P; k++) send(pl[8*k +: 8], gap);
        cyc(1'b1, ck, 1'b0);
    endtask

    function automatic logic [7:0] garbage();
        logic [7:0] b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h5A;
        return b;
    endfunction

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        int nd0, e0, t, g, kind;
        logic [63:0] pl;
        logic [7:0]  ck;

        bus.new_rx_data = 1'b0;
        bus.rx_data     = '0;
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("reset_busy",    64'(bus.busy),    64'd0);
        chk("reset_data",    bus.data,         64'd0);
        chk("reset_dropped", 64'(bus.dropped), 64'd0);
        idle(3);

        // 1: good frame, bytes spaced 10 clocks
        nd0 = nd_cnt; e0 = err_cnt;
        send_frame(64'h0807060504030201, 8'h08, 9);
        chk("t1_new_data_latency", 64'(bus.new_data), 64'd1);
        chk("t1_busy_falls",       64'(bus.busy),     64'd0);
        idle(9);
        chk("t1_data",       bus.data,              64'h0807060504030201);
        chk("t1_pulses",     64'(nd_cnt - nd0),     64'd1);
        chk("t1_no_error",   64'(err_cnt - e0),     64'd0);

        // 2: bad checksum, then a good frame
        nd0 = nd_cnt;
        send_frame(64'h0807060504030201, 8'h09, 0);
        chk("t2_error",      64'(bus.error),        64'd1);
        chk("t2_code",       64'(bus.error_code),   64'd2);
        idle(2);
        chk("t2_data_kept",  bus.data,              64'h0807060504030201);
        chk("t2_no_new",     64'(nd_cnt - nd0),     64'd0);
        send_frame(64'h1122334455667788, xor64(64'h1122334455667788), 1);
        idle(1);
        chk("t2_recovered",  bus.data,              64'h1122334455667788);

        // 3: timeout after A5,11,22
        send(SYNC, 2); send(8'h11, 2);
        cyc(1'b1, 8'h22, 1'b0);
        t = cycle;
        last_err_cycle = -1;
        for (int i = 0; i < TMO + 10 && last_err_cycle < 0; i++) idle(1);
        chk("t3_timeout_latency", 64'(last_err_cycle - t), 64'd100);
        chk("t3_code",            64'(bus.error_code),     64'd1);
        chk("t3_busy",            64'(bus.busy),           64'd0);
        idle(3);
        // 3b: byte arriving in the expiry cycle keeps the frame alive
        e0 = err_cnt; nd0 = nd_cnt;
        send(SYNC, 2); send(8'h11, 2);
        cyc(1'b1, 8'h22, 1'b0);
        idle(TMO - 1);
        cyc(1'b1, 8'h33, 1'b0);
        chk("t3b_no_error", 64'(err_cnt - e0),   64'd0);
        chk("t3b_busy",     64'(bus.busy),       64'd1);
        send(8'h44, 1); send(8'h55, 1); send(8'h66, 1); send(8'h77, 1);
        send(8'h88, 1);
        cyc(1'b1, 8'h88, 1'b0);
        idle(1);
        chk("t3b_frame",    bus.data,            64'h8877665544332211);
        chk("t3b_pulse",    64'(nd_cnt - nd0),   64'd1);

        // 4: garbage then a good frame; then drop-counter saturation
        send(8'h00, 1); send(8'hFF, 1); send(8'h3C, 1);
        chk("t4_dropped3",  64'(bus.dropped),    64'd3);
        send_frame(64'h0102030405060708, xor64(64'h0102030405060708), 0);
        chk("t4_accept",    64'(bus.new_data),   64'd1);
        for (int i = 0; i < 300; i++) send(garbage(), 0);
        chk("t4_saturate",  64'(bus.dropped),    64'd255);

        // 5: sync value inside the payload
        send_frame(64'h000000000000A5A5, 8'h00, 0);
        chk("t5_new_data",  64'(bus.new_data),   64'd1);
        chk("t5_data",      bus.data,            64'h000000000000A5A5);

        // 6: reset mid-frame
        e0 = err_cnt;
        send(SYNC, 1); send(8'h01, 1); send(8'h02, 1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t6_busy",      64'(bus.busy),       64'd0);
        idle(2);
        send_frame(64'h0807060504030201, 8'h08, 1);
        chk("t6_data",      bus.data,            64'h0807060504030201);
        chk("t6_no_error",  64'(err_cnt - e0),   64'd0);

        // Random traffic, including back-to-back strobes
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            pl = {$urandom, $urandom};
            ck = xor64(pl);
            g  = ($urandom_range(0, 19) == 0) ? TMO - 1 : int'($urandom_range(0, 3));
            if (kind <= 5) begin
                send_frame(pl, ck, g);
            end else if (kind <= 7) begin
                send_frame(pl, ck ^ (8'h01 << $urandom_range(0, 7)), g);
            end else if (kind == 8) begin
                for (int i = 0; i < int'($urandom_range(1, 4)); i++) send(garbage(), int'($urandom_range(0, 2)));
            end else begin
                send(SYNC, 0);
                for (int i = 0; i < int'($urandom_range(0, P)); i++) send(8'($urandom), 0);
                idle(TMO + int'($urandom_range(0, 5)));
            end
            idle(int'($urandom_range(0, 2)));
        end
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
